// File: rtl/count_stimulus_driver.sv
// count_stimulus_driver: issues NUM_PULSES count pulses spaced by GAP_CYCLES,
// then waits up to TIMEOUT cycles for done and reports a sticky pass/fail.
module count_stimulus_driver #(
    parameter int NUM_PULSES = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    output logic       count,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [7:0] pulses_sent
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT} state_t;
    localparam logic [7:0]  NP = 8'(NUM_PULSES);
    localparam logic [7:0]  GP = 8'(GAP_CYCLES);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    state_t      state_q, state_d;
    logic [7:0]  pulses_q, pulses_d, gap_q, gap_d;
    logic [15:0] to_q, to_d;
    logic        count_q, count_d, busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic [7:0]  ps_inc, gap_inc;
    logic [15:0] to_inc;
    always_comb begin
        state_d  = state_q;
        pulses_d = pulses_q;
        gap_d    = gap_q;
        to_d     = to_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ps_inc   = pulses_q + 8'd1;
        gap_inc  = gap_q + 8'd1;
        to_inc   = to_q + 16'd1;
        case (state_q)
            IDLE: if (start) begin
                pass_d   = 1'b0;
                fail_d   = 1'b0;
                pulses_d = 8'd0;
                busy_d   = 1'b1;
                state_d  = PULSE;
            end
            PULSE: begin
                pulses_d = ps_inc;
                gap_d    = 8'd0;
                to_d     = 16'd0;
                if (done) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else
                    state_d = (ps_inc == NP) ? WAIT : (GP == 8'd0) ? PULSE : GAP;
            end
            GAP: begin
                gap_d = gap_inc;
                if (done) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (gap_inc == GP)
                    state_d = PULSE;
            end
            WAIT: begin
                to_d = to_inc;
                if (done) begin
                    pass_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (to_inc == TO) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // count is registered from the next state so it is high exactly in PULSE
        count_d = (state_d == PULSE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pulses_q <= 8'd0;
            gap_q    <= 8'd0;
            to_q     <= 16'd0;
            count_q  <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulses_q <= pulses_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end
    assign count       = count_q;
    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign pulses_sent = pulses_q;
endmodule

// File: tb/tb_count_stimulus_driver.sv
// tb_count_stimulus_driver: directed checks of the default driver and a GAP_CYCLES=0 variant.
module tb_count_stimulus_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, done0 = 1'b0, start1 = 1'b0, done1 = 1'b0;
    logic       count0, busy0, pass0, fail0, count1, busy1, pass1, fail1;
    logic [7:0] ps0, ps1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    count_stimulus_driver u0 (
        .clk(clk), .rst(rst), .start(start0), .done(done0),
        .count(count0), .busy(busy0), .pass(pass0), .fail(fail0), .pulses_sent(ps0)
    );
    count_stimulus_driver #(.NUM_PULSES(8), .GAP_CYCLES(0), .TIMEOUT(64)) u1 (
        .clk(clk), .rst(rst), .start(start1), .done(done1),
        .count(count1), .busy(busy1), .pass(pass1), .fail(fail1), .pulses_sent(ps1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out0(input string tag, input logic c, input logic b, input logic p,
                            input logic f, input logic [7:0] n);
        chk({tag, ".count"}, 16'(count0), 16'(c));
        chk({tag, ".busy"}, 16'(busy0), 16'(b));
        chk({tag, ".pass"}, 16'(pass0), 16'(p));
        chk({tag, ".fail"}, 16'(fail0), 16'(f));
        chk({tag, ".pulses"}, 16'(ps0), 16'(n));
    endtask

    // Default-parameter run: pulses expected in cycles 1,4,...,22.
    task automatic run0(input string tag, input int last, input int done_at,
                        input int dup_start, input int rst_at);
        int  ps;
        bit  p;
        ps = 0;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int t = 1; t <= last; t++) begin
            p = (t <= 22) && ((t - 1) % 3 == 0);
            chk_out0($sformatf("%s.c%0d", tag, t), p, 1'b1, 1'b0, 1'b0, 8'(ps));
            if (p) ps++;
            done0  = (t == done_at);
            start0 = (t == dup_start) || (t == dup_start + 1);
            rst    = (t == rst_at);
            cyc();
        end
        done0  = 1'b0;
        start0 = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        chk_out0("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset1.busy", 16'(busy1), 16'd0);
        chk("reset1.pulses", 16'(ps1), 16'd0);

        run0("pass", 24, 24, -10, -10);
        chk_out0("pass.end", 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);
        for (int i = 0; i < 3; i++) cyc();
        chk_out0("idle_hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);

        run0("tmo", 86, 0, -10, -10);
        chk_out0("tmo.end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd8);

        run0("early", 8, 8, -10, -10);
        chk_out0("early.end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out0($sformatf("early.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        end

        run0("rst", 14, 0, -10, 14);
        chk_out0("rst.end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        run0("dup", 24, 24, 5, -10);
        chk_out0("dup.end", 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);

        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            chk($sformatf("g0.count%0d", t), 16'(count1), 16'(t <= 8));
            chk($sformatf("g0.busy%0d", t), 16'(busy1), 16'd1);
            chk($sformatf("g0.pulses%0d", t), 16'(ps1), 16'((t - 1 > 8) ? 8 : t - 1));
            done1 = (t == 10);
            cyc();
        end
        done1 = 1'b0;
        chk("g0.pass", 16'(pass1), 16'd1);
        chk("g0.fail", 16'(fail1), 16'd0);
        chk("g0.busy_end", 16'(busy1), 16'd0);
        chk("g0.pulses_end", 16'(ps1), 16'd8);

        done1  = 1'b1;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        chk("hi.count", 16'(count1), 16'd1);
        chk("hi.pass_cleared", 16'(pass1), 16'd0);
        cyc();
        done1 = 1'b0;
        chk("hi.fail", 16'(fail1), 16'd1);
        chk("hi.pass", 16'(pass1), 16'd0);
        chk("hi.busy", 16'(busy1), 16'd0);
        chk("hi.count_end", 16'(count1), 16'd0);
        chk("hi.pulses", 16'(ps1), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_stimulus_driver.md
# count_stimulus_driver

Drives the `count` pulse input of the counting target and watches its `done` output. It is the initiator side of the count/done interface used in the fault-injection examples. On `start` it issues a programmable number of single-cycle `count` pulses with a fixed gap between them, then waits for `done` with a timeout. It reports pass or fail, so a fault campaign can tell whether an injected fault corrupted the count.

## Interface
- `NUM_PULSES`, default 8: number of `count` pulses per run; legal range 1..255.
- `GAP_CYCLES`, default 2: idle cycles between consecutive pulses; legal range 0..255.
- `TIMEOUT`, default 64: maximum cycles to wait for `done` after the last pulse; legal range 1..65535.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `done` input 1: completion flag from the target; level, sampled every edge.
- `count` output 1: registered pulse to the target.
- `busy` output 1: high while a run is in progress.
- `pass` output 1: sticky; the run ended with `done` at the correct time.
- `fail` output 1: sticky; the run ended by early `done` or by timeout.
- `pulses_sent` output 8: number of pulses issued in the current or last run.

## Operation
- Reset values: `count`=0, `busy`=0, `pass`=0, `fail`=0, `pulses_sent`=0, state IDLE, gap and timeout counters 0.
- The FSM has states IDLE, PULSE, GAP and WAIT. `count`=1 exactly in the cycles where state==PULSE; all outputs are registered.
- IDLE:
  - `start`=1 clears `pass`, `fail` and `pulses_sent`, sets `busy`, and moves to PULSE.
  - `start`=0 holds all outputs.
- PULSE, one cycle:
  - `pulses_sent` increments by 1.
  - If the new value equals `NUM_PULSES`, go to WAIT.
  - Otherwise go to GAP; if `GAP_CYCLES`=0, go straight back to PULSE.
- GAP: `count`=0 for exactly `GAP_CYCLES` cycles, then go to PULSE.
- WAIT:
  - `count`=0 and the timeout counter increments from 0 each cycle.
  - `done`=1 sampled: set `pass`, clear `busy`, go to IDLE.
  - The counter reaches `TIMEOUT` with `done` still 0: set `fail`, clear `busy`, go to IDLE.
- Early done: `done`=1 sampled in PULSE or GAP sets `fail`, clears `busy` and goes to IDLE. No further pulses are issued. If this happens in PULSE, the pulse in that cycle has already been counted in `pulses_sent`.
- `done` already high at `start` (target not reset): the run proceeds, and the first PULSE cycle samples `done`=1, which is an early-done fail with `pulses_sent`=1.
- `start` is ignored while `busy`=1. In IDLE, `pass` and `fail` hold until the next accepted `start` or `rst`.
- `pass` and `fail` are never both 1.
- `rst` asserted mid-run returns the block to the reset values on the next edge, with no partial flags.
- Width rules:
  - `pulses_sent` is 8 bits and never wraps, because `NUM_PULSES` ≤ 255.
  - The gap counter is 8 bits.
  - The timeout counter is 16 bits, compared with equality against `TIMEOUT`.

## Timing
- `start` sampled at edge E0: `busy`=1 and `count`=1 in cycle 1, the cycle after E0.
- Pulse k (k=1..N) is high in cycle 1+(k-1)(G+1), where N=`NUM_PULSES` and G=`GAP_CYCLES`.
- WAIT begins in cycle 2+(N-1)(G+1). `done` sampled in the j-th WAIT cycle (j=1..`TIMEOUT`) gives `pass`=1 and `busy`=0 in the following cycle.
- If `done` has not been sampled by the end of the `TIMEOUT`-th WAIT cycle, `fail`=1 and `busy`=0 in the following cycle.
- Latency from `done` sampled to the flag visible is 1 cycle. From the end of a run back to IDLE accepting `start` is 0 extra cycles.

## Test plan
- Defaults, with the counting target (which raises `done` 2 cycles after its 8th pulse) connected: `start` pulse.
  - Required: 8 pulses in cycles 1, 4, …, 22.
  - Required: `pass`=1, `fail`=0, `pulses_sent`=8, `busy`=0.
- `GAP_CYCLES`=0 with `NUM_PULSES`=8:
  - Required: `count` high in 8 consecutive cycles, then WAIT.
  - Required: `pass`=1 once the target raises `done`.
- `done` tied 0 with `TIMEOUT`=64:
  - Required: `fail`=1 exactly 64 WAIT cycles after the last pulse.
  - Required: `pass`=0, `pulses_sent`=8.
- Force `done`=1 in the GAP after pulse 3:
  - Required: `fail`=1 on the next cycle, `pulses_sent`=3, and no further `count` pulses.
- Assert `rst` after pulse 5; then assert `start` while `busy` and check it is ignored:
  - Required after `rst`: all outputs 0 on the next cycle.
  - Required: a fresh run completes with `pass`=1, and a second `start` mid-run neither restarts the run nor changes the pulse spacing.
